// File: rtl/ssd_display_arbiter.sv
// ssd_display_arbiter
// Shares the 8-digit seven-segment display between a binary number source
// (converted to four BCD digits) and a priority banner requester, keeps the
// score on digit 4 and drives the multiplexed anode/segment scan.
module ssd_display_arbiter #(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int SCAN_BITS   = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] num_val,
   input  logic [3:0]  score,
   input  logic        req_msg,
   input  logic [1:0]  msg_id,
   output logic        msg_busy,
   output logic        msg_done,
   output logic [7:0]  anode,
   output logic [6:0]  ssdOut
);

   localparam int RW = SCAN_BITS + 3;
   localparam int HW = $clog2(HOLD_CYCLES);

   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
   localparam logic [RW-1:0] REF_ONE   = RW'(1);

   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_Y     = 7'b1000100;
   localparam logic [6:0] GLYPH_A     = 7'b0001000;
   localparam logic [6:0] GLYPH_F     = 7'b0111000;
   localparam logic [6:0] GLYPH_I     = 7'b1001111;
   localparam logic [6:0] GLYPH_L     = 7'b1110001;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;

   typedef enum logic {C_IDLE = 1'b0, C_SHIFT = 1'b1} conv_state_t;
   typedef enum logic {S_NUM  = 1'b0, S_MSG   = 1'b1} owner_state_t;

   // ---------------------------------------------------------------- helpers

   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b0000001;
         4'd1:    g = 7'b1001111;
         4'd2:    g = 7'b0010010;
         4'd3:    g = 7'b0000110;
         4'd4:    g = 7'b1001100;
         4'd5:    g = 7'b0100100;
         4'd6:    g = 7'b0100000;
         4'd7:    g = 7'b0001111;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0000100;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

   function automatic logic [6:0] banner_glyph(input logic [1:0] id, input logic [1:0] pos);
      logic [6:0] g;
      case ({id, pos})
         4'b0000: g = GLYPH_Y;
         4'b0001: g = GLYPH_A;
         4'b0010: g = GLYPH_Y;
         4'b0011: g = GLYPH_BLANK;
         4'b0100: g = GLYPH_F;
         4'b0101: g = GLYPH_A;
         4'b0110: g = GLYPH_I;
         4'b0111: g = GLYPH_L;
         4'b1000: g = GLYPH_8;
         4'b1001: g = GLYPH_8;
         4'b1010: g = GLYPH_8;
         4'b1011: g = GLYPH_8;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

   function automatic logic [6:0] score_glyph(input logic [3:0] s);
      return (s < 4'd8) ? digit_glyph(s) : GLYPH_BLANK;
   endfunction

   function automatic logic [15:0] saturate(input logic [15:0] v);
      return (v > 16'd9999) ? 16'd9999 : v;
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   // One double-dabble step: {bcd[15:0], bin[15:0]} -> adjusted and shifted.
   function automatic logic [31:0] dd_step(input logic [31:0] v);
      logic [31:0] t;
      t = {add3(v[31:28]), add3(v[27:24]), add3(v[23:20]), add3(v[19:16]), v[15:0]};
      return {t[30:0], 1'b0};
   endfunction

   // ------------------------------------------------------------- converter

   conv_state_t   conv_state_r, conv_next_s;
   logic [15:0]   last_r;
   logic [31:0]   dd_r;
   logic [4:0]    shift_cnt_r;
   logic [15:0]   bcd_r;
   logic          sample_s, shift_s, commit_s;

   // Converter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_state_r <= C_IDLE;
      end else begin
         conv_state_r <= conv_next_s;
      end
   end

   // Converter next state: leave idle on a new value, return after commit.
   always_comb begin
      conv_next_s = conv_state_r;
      case (conv_state_r)
         C_IDLE:  conv_next_s = (num_val != last_r) ? C_SHIFT : C_IDLE;
         C_SHIFT: conv_next_s = (shift_cnt_r == 5'd16) ? C_IDLE : C_SHIFT;
         default: conv_next_s = C_IDLE;
      endcase
   end

   // Converter controls: sample on entry, 16 shifts, then one commit cycle.
   always_comb begin
      sample_s = 1'b0;
      shift_s  = 1'b0;
      commit_s = 1'b0;
      case (conv_state_r)
         C_IDLE:  sample_s = (num_val != last_r);
         C_SHIFT: begin
            if (shift_cnt_r == 5'd16) begin
               commit_s = 1'b1;
            end else begin
               shift_s = 1'b1;
            end
         end
         default: begin
            sample_s = 1'b0;
         end
      endcase
   end

   // Converter datapath; BCD digits only change together at commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r      <= 16'd0;
         dd_r        <= 32'd0;
         shift_cnt_r <= 5'd0;
         bcd_r       <= 16'd0;
      end else if (sample_s) begin
         last_r      <= num_val;
         dd_r        <= {16'd0, saturate(num_val)};
         shift_cnt_r <= 5'd0;
      end else if (shift_s) begin
         dd_r        <= dd_step(dd_r);
         shift_cnt_r <= shift_cnt_r + 5'd1;
      end else if (commit_s) begin
         bcd_r       <= dd_r[31:16];
      end else begin
         bcd_r       <= bcd_r;
      end
   end

   // ---------------------------------------------------------- owner / banner

   owner_state_t  owner_state_r, owner_next_s;
   logic          req_prev_r;
   logic [1:0]    msg_id_r;
   logic [HW-1:0] hold_r;
   logic          msg_busy_r;
   logic          rise_s, load_s, dec_s, done_s;

   assign rise_s = req_msg & ~req_prev_r;

   // Owner state register; busy mirrors the banner owning digits 0-3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_state_r <= S_NUM;
         msg_busy_r    <= 1'b0;
      end else begin
         owner_state_r <= owner_next_s;
         msg_busy_r    <= (owner_next_s == S_MSG);
      end
   end

   // Owner next state: a retrigger always keeps the banner on screen.
   always_comb begin
      owner_next_s = owner_state_r;
      case (owner_state_r)
         S_NUM:   owner_next_s = rise_s ? S_MSG : S_NUM;
         S_MSG: begin
            if (rise_s) begin
               owner_next_s = S_MSG;
            end else if (hold_r == HOLD_ZERO) begin
               owner_next_s = S_NUM;
            end else begin
               owner_next_s = S_MSG;
            end
         end
         default: owner_next_s = S_NUM;
      endcase
   end

   // Owner controls: load on accepted edge, count down, flag expiry.
   always_comb begin
      load_s = 1'b0;
      dec_s  = 1'b0;
      done_s = 1'b0;
      case (owner_state_r)
         S_NUM:   load_s = rise_s;
         S_MSG: begin
            if (rise_s) begin
               load_s = 1'b1;
            end else if (hold_r == HOLD_ZERO) begin
               done_s = 1'b1;
            end else begin
               dec_s = 1'b1;
            end
         end
         default: begin
            load_s = 1'b0;
         end
      endcase
   end

   // Request history, banner select and hold counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_prev_r <= 1'b0;
         msg_id_r   <= 2'd0;
         hold_r     <= HOLD_ZERO;
      end else begin
         req_prev_r <= req_msg;
         if (load_s) begin
            msg_id_r <= msg_id;
            hold_r   <= HOLD_LOAD;
         end else if (dec_s) begin
            hold_r   <= hold_r - HW'(1);
         end else begin
            hold_r   <= hold_r;
         end
      end
   end

   // ---------------------------------------------------------------- scan

   logic [RW-1:0] refresh_r;
   logic [2:0]    digit_idx_s;
   logic          show_msg_s;
   logic [7:0]    an_s, anode_r;
   logic [6:0]    seg_s, ssd_r;

   assign digit_idx_s = refresh_r[SCAN_BITS+2:SCAN_BITS];
   assign show_msg_s  = (owner_state_r == S_MSG);

   // Glyph and anode selection for the digit slot currently being scanned.
   always_comb begin
      an_s  = 8'hFF;
      seg_s = GLYPH_BLANK;
      case (digit_idx_s)
         3'd0: begin
            an_s  = 8'b1111_1110;
            seg_s = show_msg_s ? banner_glyph(msg_id_r, 2'd0) : digit_glyph(bcd_r[15:12]);
         end
         3'd1: begin
            an_s  = 8'b1111_1101;
            seg_s = show_msg_s ? banner_glyph(msg_id_r, 2'd1) : digit_glyph(bcd_r[11:8]);
         end
         3'd2: begin
            an_s  = 8'b1111_1011;
            seg_s = show_msg_s ? banner_glyph(msg_id_r, 2'd2) : digit_glyph(bcd_r[7:4]);
         end
         3'd3: begin
            an_s  = 8'b1111_0111;
            seg_s = show_msg_s ? banner_glyph(msg_id_r, 2'd3) : digit_glyph(bcd_r[3:0]);
         end
         3'd4: begin
            an_s  = 8'b1110_1111;
            seg_s = score_glyph(score);
         end
         default: begin
            an_s  = 8'hFF;
            seg_s = GLYPH_BLANK;
         end
      endcase
   end

   // Refresh counter and registered pin drivers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_r <= {RW{1'b0}};
         anode_r   <= 8'hFF;
         ssd_r     <= GLYPH_BLANK;
      end else begin
         refresh_r <= refresh_r + REF_ONE;
         anode_r   <= an_s;
         ssd_r     <= seg_s;
      end
   end

   assign anode    = anode_r;
   assign ssdOut   = ssd_r;
   assign msg_busy = msg_busy_r;
   assign msg_done = done_s;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Testbench for ssd_display_arbiter: a stimulus process drives inputs and
// pushes the expected per-cycle outputs from a behavioural model into a
// queue; a monitor pops and compares on every falling clock edge.
`timescale 1ns/1ps
module tb_ssd_display_arbiter;

   localparam int HOLD = 8;
   localparam int SB   = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] num_val;
   logic [3:0]  score;
   logic        req_msg;
   logic [1:0]  msg_id;
   logic        msg_busy;
   logic        msg_done;
   logic [7:0]  anode;
   logic [6:0]  ssdOut;

   always #5 clk = ~clk;

   ssd_display_arbiter #(.HOLD_CYCLES(HOLD), .SCAN_BITS(SB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .num_val  (num_val),
      .score    (score),
      .req_msg  (req_msg),
      .msg_id   (msg_id),
      .msg_busy (msg_busy),
      .msg_done (msg_done),
      .anode    (anode),
      .ssdOut   (ssdOut)
   );

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   passes = 0;
   int   pushed = 0;
   int   popped = 0;

   // behavioural model state: values in force during the current cycle
   int m;
   int disp, last_val, conv_val, commit_edge;
   bit conv_busy;
   bit ban_act;
   int ban_id, ban_end;
   bit req_prev, req_cur;
   int id_cur, num_cur, score_cur;

   int g_num, g_sc, g_id;
   bit win;
   int busy_seen, done_seen;

   function automatic void chk(string name, int act, int req);
      checks++;
      if (act == req) begin
         passes++;
      end else begin
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endfunction

   function automatic logic [6:0] digit_seg(int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] char_seg(byte c);
      case (c)
         "Y": return 7'b1000100;
         "A": return 7'b0001000;
         "F": return 7'b0111000;
         "I": return 7'b1001111;
         "L": return 7'b1110001;
         "8": return 7'b0000000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [7:0] exp_an(int idx);
      logic [7:0] one;
      one = 8'b1;
      return (idx < 5) ? ~(one << idx) : 8'hFF;
   endfunction

   function automatic logic [6:0] exp_seg(int idx);
      string msg;
      if (idx == 4) return (score_cur < 8) ? digit_seg(score_cur) : 7'b1111111;
      if (idx > 4) return 7'b1111111;
      if (ban_act) begin
         case (ban_id)
            0: msg = "YAY ";
            1: msg = "FAIL";
            2: msg = "8888";
            default: msg = "    ";
         endcase
         return char_seg(msg[idx]);
      end
      case (idx)
         0: return digit_seg((disp / 1000) % 10);
         1: return digit_seg((disp / 100) % 10);
         2: return digit_seg((disp / 10) % 10);
         default: return digit_seg(disp % 10);
      endcase
   endfunction

   // Monitor: compare every presented output cycle against the scoreboard.
   always @(negedge clk) begin
      if (win) begin
         if (msg_busy) busy_seen++;
         if (msg_done) done_seen++;
      end
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         popped++;
         chk("anode", int'(anode), int'(mon_e.an));
         chk("ssdOut", int'(ssdOut), int'(mon_e.seg));
         chk("msg_busy", int'(msg_busy), int'(mon_e.busy));
         chk("msg_done", int'(msg_done), int'(mon_e.done));
      end
   end

   // One clock: advance the model across the edge, apply new inputs, push expectation.
   task automatic step(input bit req, input int id, input int num, input int sc);
      exp_t e;
      int   idx;
      @(posedge clk);
      m++;
      idx   = ((m - 1) >> SB) & 7;
      e.an  = exp_an(idx);
      e.seg = exp_seg(idx);
      if (conv_busy) begin
         if (m == commit_edge) begin
            disp      = conv_val;
            conv_busy = 1'b0;
         end
      end else if (num_cur != last_val) begin
         last_val    = num_cur;
         conv_val    = (num_cur > 9999) ? 9999 : num_cur;
         conv_busy   = 1'b1;
         commit_edge = m + 17;
      end
      if (req_cur && !req_prev) begin
         ban_act = 1'b1;
         ban_id  = id_cur;
         ban_end = m + HOLD;
      end else if (ban_act && m == ban_end) begin
         ban_act = 1'b0;
      end
      #1;
      req_msg   = req;
      msg_id    = id[1:0];
      num_val   = num[15:0];
      score     = sc[3:0];
      req_prev  = req_cur;
      req_cur   = req;
      id_cur    = id;
      num_cur   = num;
      score_cur = sc;
      e.busy = ban_act;
      e.done = ban_act && (ban_end == m + 1) && !(req_cur && !req_prev);
      exp_q.push_back(e);
      pushed++;
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0, g_id, g_num, g_sc);
   endtask

   task automatic pulse(input int id);
      g_id = id;
      step(1'b1, id, g_num, g_sc);
   endtask

   task automatic do_reset(input int sc);
      rst_n   = 1'b0;
      req_msg = 1'b0;
      msg_id  = 2'd0;
      num_val = 16'd0;
      score   = sc[3:0];
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m = 0; disp = 0; last_val = 0; conv_val = 0; commit_edge = 0; conv_busy = 1'b0;
      ban_act = 1'b0; ban_id = 0; ban_end = 0;
      req_prev = 1'b0; req_cur = 1'b0; id_cur = 0; num_cur = 0; score_cur = sc;
      g_num = 0; g_sc = sc; g_id = 0;
   endtask

   initial begin
      rst_n = 1'b1; req_msg = 1'b0; msg_id = 2'd0; num_val = 16'd0; score = 4'd3;
      win = 1'b0; busy_seen = 0; done_seen = 0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_anode", int'(anode), 32'hFF);
      chk("reset_ssd", int'(ssdOut), 32'h7F);
      chk("reset_busy", int'(msg_busy), 0);
      chk("reset_done", int'(msg_done), 0);

      do_reset(3);
      run(40);
      g_num = 1234;  run(40);
      g_num = 65535; run(40);
      g_num = 1234;  run(5);
      g_num = 5678;  run(60);

      g_sc = 9;
      pulse(0); run(20);

      // retrigger four cycles into a banner
      busy_seen = 0; done_seen = 0; win = 1'b1;
      pulse(0); run(3); pulse(1); run(20);
      win = 1'b0;
      chk("retrig_busy_cycles", busy_seen, HOLD + 4);
      chk("retrig_done_count", done_seen, 1);

      // retrigger coincident with expiry
      busy_seen = 0; done_seen = 0; win = 1'b1;
      pulse(2); run(HOLD - 1); pulse(3); run(20);
      win = 1'b0;
      chk("coinc_busy_cycles", busy_seen, 2 * HOLD);
      chk("coinc_done_count", done_seen, 1);

      // randomized traffic
      g_sc = 5;
      repeat (1500) begin
         int r;
         r = $urandom_range(0, 199);
         if (r < 3) g_num = $urandom_range(0, 65535);
         else if (r == 3) g_num = 9999;
         else if (r == 4) g_num = 10000;
         if ($urandom_range(0, 49) == 0) g_sc = $urandom_range(0, 15);
         if ($urandom_range(0, 29) == 0) pulse($urandom_range(0, 3));
         else step(1'b0, g_id, g_num, g_sc);
      end
      run(40);

      // reset in the middle of a banner
      pulse(1); run(3);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(msg_busy), 0);
      chk("midrst_done", int'(msg_done), 0);
      chk("midrst_anode", int'(anode), 32'hFF);
      chk("midrst_ssd", int'(ssdOut), 32'h7F);
      do_reset(2);
      run(40);
      g_num = 4321; run(60);

      @(negedge clk);
      #1;
      chk("scoreboard_drained", popped, pushed);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
